// File: rtl/adder_output_error_monitor.sv
// rtl/adder_output_error_monitor.sv - mismatch statistics between locked and golden adder results
//
// Compares the locked-netlist result against the golden-netlist result over a
// run of NUM_VECTORS accepted vectors and accumulates corruption statistics.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    1-cycle pulse in IDLE: clear statistics, begin run
//   in_valid / in_ready      vector handshake (in_ready is a function of state only)
//   locked_result            result from the locked adder
//   golden_result            result from the oracle adder
//   busy                     run in progress (RUN or DRAIN)
//   done                     1-cycle pulse once statistics are final
//   vec_count                vectors accounted this run
//   err_vec_count            vectors with any mismatching bit
//   bit_err_count            sum of per-vector Hamming distances
//   max_hd                   largest single-vector Hamming distance
//   first_err_idx/_vld       0-based index of the first mismatching vector

module adder_output_error_monitor #(
  parameter int WIDTH       = 17,
  parameter int NUM_VECTORS = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] locked_result,
  input  logic [WIDTH-1:0] golden_result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_vec_count,
  output logic [CNT_W-1:0] bit_err_count,
  output logic [4:0]       max_hd,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state;
  logic [CNT_W-1:0] acc_cnt;
  logic             drain_cnt;
  logic             accept;
  logic             clear_stats;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_diff;
  logic             s2_valid;
  logic [4:0]       s2_hd;
  logic [4:0]       hd_c;

  assign accept      = in_valid & in_ready;
  assign clear_stats = start && (state == IDLE);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    hd_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd_c = hd_c + {4'b0, s1_diff[i]};
    end
  end

  // Control FSM; all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            acc_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == LAST_IDX) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles lets the last accepted vector reach the statistics.
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data registers only load on a valid beat so idle cycles never disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s2_valid <= 1'b0;
      s2_hd    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_diff <= locked_result ^ golden_result;
      s2_valid <= s1_valid;
      if (s1_valid) s2_hd <= hd_c;
    end
  end

  // vec_count doubles as the index of the vector being accounted, since
  // vectors leave the pipeline in acceptance order.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      vec_count     <= '0;
      err_vec_count <= '0;
      bit_err_count <= '0;
      max_hd        <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (s2_valid) begin
      vec_count     <= sat_add(vec_count, CNT_W'(1));
      bit_err_count <= sat_add(bit_err_count, CNT_W'(s2_hd));
      if (s2_hd != 5'd0) begin
        err_vec_count <= sat_add(err_vec_count, CNT_W'(1));
        if (!first_err_vld) begin
          first_err_idx <= vec_count;
          first_err_vld <= 1'b1;
        end
      end
      if (s2_hd > max_hd) max_hd <= s2_hd;
    end
  end

endmodule

// File: tb/tb_adder_output_error_monitor.sv
// tb/tb_adder_output_error_monitor.sv - scoreboard bench for adder_output_error_monitor

module tb_adder_output_error_monitor;

  localparam int WIDTH = 17;
  localparam int NV    = 4;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] locked_result;
  logic [WIDTH-1:0] golden_result;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_vec_count;
  logic [CNT_W-1:0] bit_err_count;
  logic [4:0]       max_hd;
  logic [CNT_W-1:0] first_err_idx;
  logic             first_err_vld;

  typedef struct {
    int vc;
    int evc;
    int bec;
    int mhd;
    int fidx;
    int fvld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  adder_output_error_monitor #(.WIDTH(WIDTH), .NUM_VECTORS(NV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .locked_result(locked_result), .golden_result(golden_result),
    .busy(busy), .done(done), .vec_count(vec_count), .err_vec_count(err_vec_count),
    .bit_err_count(bit_err_count), .max_hd(max_hd), .first_err_idx(first_err_idx),
    .first_err_vld(first_err_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("vec_count",     vec_count,     e.vc);
        chk("err_vec_count", err_vec_count, e.evc);
        chk("bit_err_count", bit_err_count, e.bec);
        chk("max_hd",        max_hd,        e.mhd);
        chk("first_err_idx", first_err_idx, e.fidx);
        chk("first_err_vld", first_err_vld, e.fvld);
      end
    end
  end

  task automatic push_exp(input int vc, evc, bec, mhd, fidx, fvld);
    exp_t e;
    e.vc = vc; e.evc = evc; e.bec = bec; e.mhd = mhd; e.fidx = fidx; e.fvld = fvld;
    exp_q.push_back(e);
  endtask

  // All drive tasks start and end at posedge+1.
  task automatic drive(input logic v, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] g);
    in_valid = v; locked_result = l; golden_result = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns how many falling edges elapsed until done was seen (0 on timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_stats"}, err_vec_count | bit_err_count | max_hd | first_err_idx, 0);
    chk({tag, "_first_err_vld"}, first_err_vld, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    locked_result = '0; golden_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_zero("reset");

    // Test 1: clean run, done two edges after the last accept.
    pulse_start();
    push_exp(4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 17'h01234, 17'h01234);
    wait_done(n);
    chk("t1_done_latency", n, 3);

    // Test 2: single full-width error at index 2.
    pulse_start();
    push_exp(4, 1, 17, 17, 2, 1);
    drive(1'b1, 17'h0AAAA, 17'h0AAAA);
    drive(1'b1, 17'h0AAAA, 17'h0AAAA);
    drive(1'b1, 17'h1FFFF, 17'h00000);
    drive(1'b1, 17'h0AAAA, 17'h0AAAA);
    wait_done(n);

    // Test 3: toggled in_valid; garbage on invalid beats must not count.
    pulse_start();
    push_exp(4, 4, 8, 2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        @(negedge clk);
        chk("t3_ready_before_last", in_ready, 1);
        @(posedge clk); #1;
      end
      drive(1'b1, 17'h00003, 17'h00000);
      if (i < 3) drive(1'b0, 17'h1FFFF, 17'h00000);
    end
    @(negedge clk);
    chk("t3_ready_after_last", in_ready, 0);
    wait_done(n);
    chk("t3_done_latency", n, 2);

    // Test 4: reset mid-run aborts with no done pulse.
    pulse_start();
    drive(1'b1, 17'h1FFFF, 17'h00000);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t4_vec_count_before_rst", vec_count, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("t4_abort");
    repeat (10) begin @(posedge clk); #1; end

    // Test 5: start pulses in RUN and DRAIN are ignored.
    pulse_start();
    push_exp(4, 2, 3, 2, 0, 1);
    drive(1'b1, 17'h00001, 17'h00000);
    pulse_start();
    drive(1'b1, 17'h00055, 17'h00055);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t5_vec_count_after_start", vec_count, 2);
    chk("t5_first_err_vld_kept", first_err_vld, 1);
    @(posedge clk); #1;
    drive(1'b1, 17'h00055, 17'h00055);
    drive(1'b1, 17'h10001, 17'h00000);
    pulse_start();
    wait_done(n);

    // Test 6: errored run followed directly by a clean run.
    pulse_start();
    push_exp(4, 2, 9, 8, 1, 1);
    drive(1'b1, 17'h00000, 17'h00000);
    drive(1'b1, 17'h00F0F, 17'h00000);
    drive(1'b1, 17'h00000, 17'h00000);
    drive(1'b1, 17'h00001, 17'h00003);
    wait_done(n);
    pulse_start();
    push_exp(4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 17'h1C3A5, 17'h1C3A5);
    wait_done(n);

    repeat (5) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
